// File: rtl/counter_reload_ctrl4.sv
// Reload controller for a 4-bit loadable up-counter: turns COUT into a programmable
// one-shot or periodic timer with a shadowed period register and an expiry counter.
module counter_reload_ctrl4 #(
  parameter int TCNT_W = 8
) (
  input  logic              CLK,
  input  logic              ASYNCRESET,
  input  logic [3:0]        PERIOD,
  input  logic              PERIOD_VALID,
  output logic              PERIOD_READY,
  input  logic              START,
  input  logic              STOP,
  input  logic              MODE,
  input  logic              CNT_COUT,
  output logic [3:0]        DATA,
  output logic              LOAD,
  output logic              TICK,
  output logic              BUSY,
  output logic [TCNT_W-1:0] TICK_CNT
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        active_q, shadow_q;
  logic              pending_q;
  logic [TCNT_W-1:0] tick_cnt_q;
  logic              accept;
  logic              clr_cnt;
  logic [3:0]        eff;

  // Period N (0 meaning 16) becomes the value that leaves N counts until COUT.
  function automatic logic [3:0] reload_value(input logic [3:0] n);
    return 4'd0 - n;
  endfunction

  assign PERIOD_READY = !pending_q;
  assign accept       = PERIOD_VALID && !pending_q;
  assign eff          = pending_q ? shadow_q : active_q;
  assign DATA         = reload_value(eff);
  assign BUSY         = (state_q == RUN);
  assign TICK_CNT     = tick_cnt_q;

  always_comb begin
    state_d = state_q;
    LOAD    = 1'b0;
    TICK    = 1'b0;
    clr_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          LOAD    = 1'b1;
          clr_cnt = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        TICK = CNT_COUT;
        if (STOP) begin
          state_d = IDLE;
        end else if (START) begin
          LOAD    = 1'b1;
          clr_cnt = 1'b1;
        end else if (CNT_COUT && MODE) begin
          LOAD = 1'b1;
        end else if (CNT_COUT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr_cnt)
        tick_cnt_q <= '0;
      else if (TICK)
        tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  // A new period only reaches active at a reload (or immediately while idle),
  // so the interval in flight always completes with the period it started with.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (accept) begin
        shadow_q  <= PERIOD;
        pending_q <= 1'b1;
      end else if (LOAD || state_q == IDLE) begin
        pending_q <= 1'b0;
      end
      if (LOAD)
        active_q <= eff;
      else if (state_q == IDLE && pending_q)
        active_q <= shadow_q;
    end
  end

endmodule

// File: doc/counter_reload_ctrl4.md
# counter_reload_ctrl4

Reload controller for the 4-bit loadable up-counter with carry-out. It drives the counter's DATA/LOAD pair and consumes its COUT to turn the free-running counter into a programmable one-shot or periodic timer. Expiry period is 1..16 cycles. The period is written through a valid/ready port and applied glitch-free at the next reload boundary. The block emits a TICK per expiry and keeps a count of expiries.

## Interface
Parameters:
- TCNT_W, 8: width of the expiry counter TICK_CNT.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock, rising edge.
- ASYNCRESET  in  1  asynchronous, active-high reset.
- PERIOD  in  4  requested period N; 0 encodes 16.
- PERIOD_VALID  in  1  PERIOD is offered.
- PERIOD_READY  out  1  shadow register free; transfer when VALID&READY.
- START  in  1  start/restart the timer (single-cycle pulse expected; level is legal).
- STOP  in  1  abort to IDLE.
- MODE  in  1  0 = one-shot, 1 = periodic; sampled at each expiry.
- CNT_COUT  in  1  counter COUT (high when counter register = 15).
- DATA  out  4  counter load value.
- LOAD  out  1  counter load strobe.
- TICK  out  1  expiry pulse.
- BUSY  out  1  state == RUN.
- TICK_CNT  out  TCNT_W  expiries since last START; wraps.

## Operation
- State: FSM {IDLE, RUN}; active[3:0]; shadow[3:0]; pending; tick_cnt.
- PERIOD_READY = !pending. On VALID&READY: shadow <= PERIOD, pending <= 1.
- Effective period eff = pending ? shadow : active. DATA = (0 - eff) mod 16, driven combinationally and always. Because 0 encodes 16, N maps to a load value L = 16 - N, so the counter reaches 15 after exactly N register values.
- Reload event is any cycle with LOAD=1. On a reload event: active <= eff, pending <= 0. An accept cannot occur in the same cycle, since READY is 0 while pending.
- In IDLE, pending is transferred every cycle: active <= shadow, pending <= 0.
- IDLE:
  - LOAD = 0, TICK = 0.
  - START -> LOAD = 1, tick_cnt <= 0, next RUN.
  - CNT_COUT is ignored.
- RUN, evaluated in priority order:
  - TICK = CNT_COUT.
  - STOP -> next IDLE, LOAD = 0; TICK still reflects CNT_COUT.
  - Else START -> LOAD = 1, stay RUN (restart); tick_cnt <= 0, and a coincident TICK is not counted.
  - Else CNT_COUT & MODE -> LOAD = 1, stay RUN.
  - Else CNT_COUT & !MODE -> next IDLE, LOAD = 0.
- tick_cnt increments by 1 on TICK (mod 2^TCNT_W), except where cleared as above.
- LOAD and TICK are combinational from registered state, START, STOP, MODE and CNT_COUT. The path CNT_COUT -> LOAD is deliberate, so the reload lands in the same cycle as the overflow.

## Timing
- Reset values:
  - State IDLE; active = shadow = 0; pending = 0; tick_cnt = 0.
  - Outputs: PERIOD_READY = 1, DATA = 0, LOAD = 0, TICK = 0, BUSY = 0, TICK_CNT = 0.
- Reset mid-RUN returns to IDLE immediately, asynchronously; outputs take the reset values, and any pending period is discarded.
- START in IDLE at cycle t: LOAD at t; counter holds L at t+1; first TICK at t+N.
- Periodic mode: TICK every N cycles thereafter, with no slip.
- N = 1 (PERIOD = 1, L = 15): TICK and LOAD every cycle starting at t+1.
- N = 16 (PERIOD = 0): L = 0, TICK at t+16.
- A period written during RUN takes effect at the next reload; the current interval is unaffected.
- BUSY and TICK_CNT are registered; TICK_CNT reflects a TICK one cycle later.
- PERIOD_READY deasserts the cycle after an accept and reasserts the cycle after the next reload event (RUN) or the next cycle (IDLE).

## Test plan
- Reset, PERIOD = 4 accepted, MODE = 1, START at cycle 0 -> LOAD/DATA = 12 at cycle 0; TICK at cycles 4, 8, 12; TICK_CNT = 3 at cycle 13.
- MODE = 0, PERIOD = 3, START -> single TICK at cycle 3, BUSY falls at cycle 4, no LOAD at cycle 3.
- Running with N = 4, write PERIOD = 2 at cycle 5 -> PERIOD_READY = 0 from cycle 6; TICK at 8 with DATA = 14; then TICKs at 10, 12; READY = 1 at cycle 9.
- PERIOD = 0 (16) and PERIOD = 1 -> TICK spacing 16 and 1 cycles respectively.
- STOP coincident with CNT_COUT -> TICK = 1, LOAD = 0, IDLE next cycle. START coincident with CNT_COUT -> LOAD once, TICK_CNT = 0 next cycle.
- ASYNCRESET pulsed mid-interval, asynchronously to CLK -> all outputs at reset values before the next edge; a later START behaves as a fresh start with period 16.
